// File: rtl/pmic_rail_sequencer.sv
// Four-rail PMIC power sequencer: steps rails up/down in thermometer order toward a
// target set by on_req/lp_req. Define PMIC_PG_TIMEOUT_EN for pg-timeout and pg-loss faults.
module pmic_rail_sequencer #(
    parameter int unsigned STEP_DLY   = 8,
    parameter int unsigned PG_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       on_req,
    input  logic       lp_req,
    input  logic [3:0] rail_pg,
    output logic [3:0] rail_en,
    output logic [2:0] level,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UP_PG  = 3'd1,
        UP_DLY = 3'd2,
        DN_DLY = 3'd3,
        FAULT  = 3'd4
    } state_t;

    if (STEP_DLY < 1 || STEP_DLY > 255) begin : g_bad_step_dly
        $error("STEP_DLY must be within 1..255");
    end
    if (PG_TIMEOUT < 1 || PG_TIMEOUT > 255) begin : g_bad_pg_timeout
        $error("PG_TIMEOUT must be within 1..255");
    end

    // Counter is loaded with STEP_DLY-1 so the delay states last exactly STEP_DLY cycles.
    localparam logic [7:0] DLY_LAST = 8'(STEP_DLY - 1);

    state_t     state_q, state_d;
    logic [2:0] level_q, level_d;
    logic [3:0] rail_en_q, rail_en_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       fault_q, fault_d;
    logic [2:0] target;
    logic       top_pg;

`ifdef PMIC_PG_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(PG_TIMEOUT - 1);
    logic [7:0] tcnt_q, tcnt_d;
    logic       pg_lost;
`endif

    function automatic logic [3:0] therm(input logic [2:0] n);
        case (n)
            3'd0:    therm = 4'b0000;
            3'd1:    therm = 4'b0001;
            3'd2:    therm = 4'b0011;
            3'd3:    therm = 4'b0111;
            default: therm = 4'b1111;
        endcase
    endfunction

    // on_req=0 wins over any lp_req value.
    always_comb begin
        target = 3'd4;
        if (!on_req) begin
            target = 3'd0;
        end else if (lp_req) begin
            target = 3'd2;
        end
    end

    always_comb begin
        case (level_q)
            3'd1:    top_pg = rail_pg[0];
            3'd2:    top_pg = rail_pg[1];
            3'd3:    top_pg = rail_pg[2];
            3'd4:    top_pg = rail_pg[3];
            default: top_pg = 1'b0;
        endcase
    end

`ifdef PMIC_PG_TIMEOUT_EN
    assign pg_lost = |(rail_en_q & ~rail_pg);
`endif

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
`ifdef PMIC_PG_TIMEOUT_EN
        tcnt_d  = tcnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef PMIC_PG_TIMEOUT_EN
                if (pg_lost) begin
                    state_d = FAULT;
                end else
`endif
                if (level_q < target) begin
                    level_d = level_q + 3'd1;
                    state_d = UP_PG;
`ifdef PMIC_PG_TIMEOUT_EN
                    tcnt_d  = 8'd0;
`endif
                end else if (level_q > target) begin
                    level_d = level_q - 3'd1;
                    cnt_d   = DLY_LAST;
                    state_d = DN_DLY;
                end
            end
            UP_PG: begin
                // A falling target reverses the ramp without waiting for power-good.
                if (target < level_q) begin
                    level_d = level_q - 3'd1;
                    cnt_d   = DLY_LAST;
                    state_d = DN_DLY;
                end else if (top_pg) begin
                    cnt_d   = DLY_LAST;
                    state_d = UP_DLY;
                end
`ifdef PMIC_PG_TIMEOUT_EN
                else if (tcnt_q == TO_LAST) begin
                    state_d = FAULT;
                end else begin
                    tcnt_d  = tcnt_q + 8'd1;
                end
`endif
            end
            UP_DLY, DN_DLY: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                end
            end
            FAULT: begin
                if (!on_req) begin
                    state_d = IDLE;
                    fault_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Fault entry drops every rail at once.
        if (state_d == FAULT && state_q != FAULT) begin
            level_d = 3'd0;
            fault_d = 1'b1;
        end

        rail_en_d = therm(level_d);
        busy_d    = (state_d == UP_PG) || (state_d == UP_DLY) || (state_d == DN_DLY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            level_q   <= 3'd0;
            rail_en_q <= 4'b0000;
            cnt_q     <= 8'd0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
`ifdef PMIC_PG_TIMEOUT_EN
            tcnt_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            rail_en_q <= rail_en_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            fault_q   <= fault_d;
`ifdef PMIC_PG_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
`endif
        end
    end

    assign rail_en = rail_en_q;
    assign level   = level_q;
    assign busy    = busy_q;
    assign fault   = fault_q;

endmodule
